// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Brings up the board PLL that produces the system and SDRAM clocks. It also
// holds the design-wide reset until that PLL has been locked for long enough.
// The sequence is:
//   1. Pulse the PLL areset.
//   2. Wait for a synchronised lock indication.
//   3. Require lock to stay high for a programmable number of cycles.
//   4. Release sys_reset.
// A lock timeout, or a loss of lock while running, re-resets the PLL and
// bumps a saturating fault counter.
//
// Ports:
//   clk          50 MHz reference clock (PLL refclk domain)
//   reset        synchronous, active-high reset
//   locked_in    PLL locked flag, asynchronous to clk
//   pll_rst      PLL areset, active high (registered)
//   sys_reset    reset for all PLL-clocked logic, active high (registered)
//   running      high while lock is qualified and sys_reset is released
//   fault_count  saturating count of lock timeouts plus lock losses
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_WIDTH      = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked_in,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       running,
    output logic [7:0] fault_count
);

    typedef enum logic [1:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    // Terminal counts are "limit - 1" because the counter starts at 0
    // on the first cycle in each state.
    localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic                 lock_meta;
    logic                 locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    // A change on locked_in reaches locked_s two clocks later.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= locked_in;
            locked_s  <= lock_meta;
        end
    end

    // Increments the fault count, but holds it at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Sequencer FSM.
    // One counter is shared by every state and is cleared on each transition.
    // All outputs are registered and updated together with the state.
    // Entering PLL_RESET from another state sets pll_rst on that same edge.
    // This gives every pulse exactly PLL_RST_CYCLES high cycles, matching
    // the pulse that follows reset deassertion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLL_RESET;
            counter     <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            running     <= 1'b0;
            fault_count <= 8'd0;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (counter == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        counter <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                // When lock and timeout coincide, lock has priority.
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state   <= STABLE;
                        counter <= '0;
                    end else if (counter == TIMEOUT_LAST) begin
                        state       <= PLL_RESET;
                        counter     <= '0;
                        pll_rst     <= 1'b1;
                        fault_count <= sat_inc(fault_count);
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                // A dropout during qualification is not a fault.
                // It restarts the lock wait with a fresh timeout window.
                // A dropout on the final cycle still aborts.
                STABLE: begin
                    if (!locked_s) begin
                        state   <= WAIT_LOCK;
                        counter <= '0;
                    end else if (counter == STABLE_LAST) begin
                        state     <= RUN;
                        counter   <= '0;
                        sys_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                RUN: begin
                    if (!locked_s) begin
                        state       <= PLL_RESET;
                        counter     <= '0;
                        pll_rst     <= 1'b1;
                        sys_reset   <= 1'b1;
                        running     <= 1'b0;
                        fault_count <= sat_inc(fault_count);
                    end
                end

                default: begin
                    state     <= PLL_RESET;
                    counter   <= '0;
                    pll_rst   <= 1'b1;
                    sys_reset <= 1'b1;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule
